// File: rtl/sha1_pad.sv
// SHA-1 message padder: packs a 32-bit big-endian word stream into
// padded 512-bit blocks (0x80, zero fill, 64-bit bit length).
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   din, din_valid, din_ready  message word stream (valid/ready)
//   din_last, din_nbytes       final word marker, bytes used in it
//   block, block_valid,        padded block out (valid/ready),
//   block_last, block_ready    block_last marks the message's final block
module sha1_pad #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] din,
  input  logic         din_valid,
  input  logic         din_last,
  input  logic [2:0]   din_nbytes,
  output logic         din_ready,
  output logic [511:0] block,
  output logic         block_valid,
  output logic         block_last,
  input  logic         block_ready
);

  localparam logic [1:0] FILL = 2'd0;
  localparam logic [1:0] PAD  = 2'd1;
  localparam logic [1:0] EMIT = 2'd2;

  logic [1:0]  state;
  logic [3:0]  s;
  logic [63:0] len;
  logic        pend80;
  logic        lenhi_done;
  logic        pad_next;

  logic [2:0]  nb_eff;
  logic [5:0]  add_bits;
  logic [N-1:0] last_word;
  logic [31:0] pad_word;
  logic        pad_final;
  logic [8:0]  base;

  assign din_ready = (state == FILL);
  assign base      = {~s, 5'd0};
  assign pad_final = !pend80 && lenhi_done && (s == 4'd15);

  always_comb begin
    nb_eff    = din_nbytes[2] ? 3'd4 : din_nbytes;
    add_bits  = din_last ? {nb_eff, 3'd0} : 6'd32;
    last_word = din;
    unique case (nb_eff)
      3'd0:    last_word = 32'h8000_0000;
      3'd1:    last_word = {din[31:24], 24'h80_0000};
      3'd2:    last_word = {din[31:16], 16'h8000};
      3'd3:    last_word = {din[31:8], 8'h80};
      default: last_word = din;
    endcase
  end

  always_comb begin
    pad_word = 32'd0;
    if (pend80)
      pad_word = 32'h8000_0000;
    else if (s == 4'd14)
      pad_word = len[63:32];
    else if (s == 4'd15 && lenhi_done)
      pad_word = len[31:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FILL;
      s           <= 4'd0;
      len         <= 64'd0;
      pend80      <= 1'b0;
      lenhi_done  <= 1'b0;
      pad_next    <= 1'b0;
      block       <= 512'd0;
      block_valid <= 1'b0;
      block_last  <= 1'b0;
    end else begin
      unique case (state)
        FILL: begin
          if (din_valid) begin
            block[base +: 32] <= din_last ? last_word : din;
            len <= len + {58'd0, add_bits};
            if (din_last)
              pend80 <= (nb_eff == 3'd4);
            if (s == 4'd15) begin
              state       <= EMIT;
              block_valid <= 1'b1;
              block_last  <= 1'b0;
              pad_next    <= din_last;
            end else begin
              s <= s + 4'd1;
              if (din_last)
                state <= PAD;
            end
          end
        end
        PAD: begin
          block[base +: 32] <= pad_word;
          if (pend80)
            pend80 <= 1'b0;
          else if (s == 4'd14)
            lenhi_done <= 1'b1;
          if (s == 4'd15) begin
            state       <= EMIT;
            block_valid <= 1'b1;
            block_last  <= pad_final;
            pad_next    <= !pad_final;
          end else begin
            s <= s + 4'd1;
          end
        end
        EMIT: begin
          if (block_ready) begin
            s           <= 4'd0;
            block_valid <= 1'b0;
            lenhi_done  <= 1'b0;
            state       <= pad_next ? PAD : FILL;
            if (block_last)
              len <= 64'd0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_pad.sv
// Directed bench for sha1_pad: known padded blocks for several
// message lengths, latency, backpressure and mid-message reset.
module tb_sha1_pad;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  din = '0;
  logic         din_valid = 1'b0;
  logic         din_last = 1'b0;
  logic [2:0]   din_nbytes = '0;
  logic         din_ready;
  logic [511:0] block;
  logic         block_valid;
  logic         block_last;
  logic         block_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  sha1_pad #(.N(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .din(din), .din_valid(din_valid),
    .din_last(din_last), .din_nbytes(din_nbytes),
    .din_ready(din_ready),
    .block(block), .block_valid(block_valid),
    .block_last(block_last), .block_ready(block_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [511:0] got,
                       input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dw(input int k);
    return {8'(4*k+1), 8'(4*k+2), 8'(4*k+3), 8'(4*k+4)};
  endfunction

  function automatic logic [511:0] pack(input logic [31:0] w[16]);
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[511-32*i -: 32] = w[i];
    return b;
  endfunction

  task automatic send(input logic [31:0] d, input logic l,
                      input logic [2:0] nb);
    int n;
    @(negedge clk);
    din = d; din_last = l; din_nbytes = nb; din_valid = 1'b1;
    n = 0;
    while (!din_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!din_ready) check("din_ready_timeout", 0, 1);
    @(posedge clk);
    #1 din_valid = 1'b0;
  endtask

  // Cycle index (accept cycle = 0) at which block_valid is first seen.
  task automatic wait_valid(output int n);
    n = 1;
    while (!block_valid && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    if (!block_valid) check("valid_timeout", 0, 1);
  endtask

  task automatic take(input string tag, input logic [511:0] eb,
                      input logic el);
    int n;
    wait_valid(n);
    check({tag, "_block"}, block, eb);
    check({tag, "_last"}, block_last, el);
    @(negedge clk);
    block_ready = 1'b1;
    @(posedge clk);
    #1 block_ready = 1'b0;
  endtask

  // Message of nb total bytes, byte i = i+1; unused bytes set to 0xEE.
  task automatic send_msg(input int nb);
    int nw;
    logic [31:0] w;
    int r;
    nw = (nb == 0) ? 1 : (nb + 3) / 4;
    for (int k = 0; k < nw; k++) begin
      w = dw(k);
      if (k == nw - 1) begin
        r = nb - 4 * k;
        for (int j = r; j < 4; j++) w[31-8*j -: 8] = 8'hEE;
        send(w, 1'b1, 3'(r));
      end else begin
        send(w, 1'b0, 3'd4);
      end
    end
  endtask

  logic [31:0]  ew[16];
  logic [511:0] abc_blk;
  logic [511:0] eb;
  int lat;

  initial begin
    for (int i = 0; i < 16; i++) ew[i] = 32'd0;
    ew[0] = 32'h6162_6380;
    ew[15] = 32'h0000_0018;
    abc_blk = pack(ew);

    #12;
    check("rst_din_ready", din_ready, 1);
    check("rst_block_valid", block_valid, 0);
    check("rst_block_last", block_last, 0);
    check("rst_block", block, 0);
    @(negedge clk) rst_n = 1'b1;

    send(32'h6162_6300, 1'b1, 3'd3);
    wait_valid(lat);
    check("abc_latency", 32'(lat), 16);
    take("abc", abc_blk, 1'b1);

    for (int i = 0; i < 16; i++) ew[i] = 32'd0;
    ew[0] = 32'h8000_0000;
    send(32'hDEAD_BEEF, 1'b1, 3'd0);
    take("empty", pack(ew), 1'b1);

    for (int i = 0; i < 16; i++) ew[i] = (i < 13) ? dw(i) : 32'd0;
    ew[13] = 32'h3536_3780;
    ew[15] = 32'h0000_01B8;
    send_msg(55);
    wait_valid(lat);
    check("b55_latency", 32'(lat), 3);
    take("b55", pack(ew), 1'b1);

    for (int i = 0; i < 16; i++) ew[i] = (i < 14) ? dw(i) : 32'd0;
    ew[14] = 32'h8000_0000;
    send_msg(56);
    take("b56_1", pack(ew), 1'b0);
    for (int i = 0; i < 16; i++) ew[i] = 32'd0;
    ew[15] = 32'h0000_01C0;
    take("b56_2", pack(ew), 1'b1);

    for (int i = 0; i < 16; i++) ew[i] = dw(i);
    send_msg(64);
    wait_valid(lat);
    check("b64_latency", 32'(lat), 1);
    take("b64_1", pack(ew), 1'b0);
    for (int i = 0; i < 16; i++) ew[i] = 32'd0;
    ew[0] = 32'h8000_0000;
    ew[15] = 32'h0000_0200;
    take("b64_2", pack(ew), 1'b1);

    send(32'h6162_6300, 1'b1, 3'd3);
    wait_valid(lat);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_block", block, abc_blk);
      check("bp_last", block_last, 1);
      check("bp_din_ready", din_ready, 0);
    end
    take("bp", abc_blk, 1'b1);

    send(32'h7778_7900, 1'b1, 3'd3);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", block_valid, 0);
    check("rst_mid_ready", din_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    send(32'h6162_6300, 1'b1, 3'd3);
    take("abc_again", abc_blk, 1'b1);

    send(32'h6162_6300, 1'b1, 3'd3);
    wait_valid(lat);
    #1 rst_n = 1'b0;
    #1;
    check("rst_emit_valid", block_valid, 0);
    @(negedge clk) rst_n = 1'b1;
    send(32'h6100_0000, 1'b1, 3'd1);
    for (int i = 0; i < 16; i++) ew[i] = 32'd0;
    ew[0] = 32'h6180_0000;
    ew[15] = 32'h0000_0008;
    eb = pack(ew);
    take("one_byte", eb, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sha1_pad.md
Name: sha1_pad

Overview:
- Upstream neighbour of the SHA-1 message-schedule stage.
- Accepts a big-endian 32-bit word stream for one message and applies FIPS 180-4 padding: a 0x80 byte, zero fill, then the 64-bit bit length.
- Emits complete 512-bit blocks with a valid/ready handshake. The top level pulses the schedule stage's load (valid_w at t==0) from block_valid&&block_ready.
- Handles messages of any byte length, including empty, and the extra-block case.

Parameters:
- N, 32, word width; fixed at 32 for SHA-1. Other values are unsupported.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous reset, active-low
- din  input  32  message word; first message byte in [31:24]
- din_valid  input  1  din/din_last/din_nbytes valid
- din_last  input  1  final word of the message
- din_nbytes  input  3  valid bytes in the final word, 0..4, left-justified; ignored (treated as 4) when din_last=0
- din_ready  output  1  word accepted when din_valid&&din_ready
- block  output  512  padded block; slot 0 in [511:480], slot 15 in [31:0]
- block_valid  output  1  block holds a complete 512-bit block
- block_last  output  1  block is the final block of the message; qualified by block_valid
- block_ready  input  1  consumer takes block when block_valid&&block_ready

Behaviour:
- Reset (async, rst_n=0):
  - state=FILL, slot counter s=0, bit-length counter len=0.
  - pend80=0, lenhi_done=0, block=0, block_valid=0, block_last=0.
- din_ready = (state==FILL). It reads 1 during and after reset; inputs are ignored while rst_n=0.
- Length counter (64-bit, wraps mod 2^64):
  - Accepted non-last word: len += 32.
  - Accepted last word: len += 8*din_nbytes.
  - Cleared on the handshake of a block_last block.
- FILL, per accepted word, written to slot s:
  - Not last:
    - Slot s = din.
    - If s==15: go to EMIT with final=0, then resume FILL.
    - Else s++.
  - Last with nbytes<4:
    - Slot s = din bytes 0..nbytes-1, then 0x80 at byte nbytes, remaining bytes 0. Data bytes beyond nbytes are ignored and forced to 0.
    - nbytes=0 gives 0x80000000.
  - Last with nbytes==4: slot s = din, and pend80 is set.
  - After a last word:
    - If s==15: go to EMIT with final=0, with padding continuing afterwards.
    - Else: s++ and go to PAD.
- PAD, one slot per cycle; din_ready=0. Slot s is written as follows:
  - If pend80: 0x80000000; clear pend80.
  - Else if s==14: len[63:32]; set lenhi_done.
  - Else if s==15 and lenhi_done: len[31:0]; go to EMIT with final=1.
  - Else: 0.
  - At s==15 when the length has not been written: go to EMIT with final=0, with padding continuing afterwards.
  - Otherwise s++.
- The length value used is the total after the last word.
- EMIT:
  - block_valid=1; block and block_last stay stable until the handshake.
  - On handshake: s=0, block_valid=0, lenhi_done=0. Next state:
    - FILL if the block was data-full or final.
    - PAD if padding continues; pend80 is preserved.
  - Handshake to the next din_ready rising or block_valid rising: 1 cycle.
- Latency and throughput:
  - From the last-word accept to block_valid for a single-block final: 16-s_last cycles.
  - Data-full blocks: block_valid is asserted the cycle after slot 15 is accepted.
  - Sustained input is 1 word/cycle, with 1 bubble per block for EMIT.
- Block register: each slot is written before emission, so no clearing is needed between blocks.
- Extra block required when:
  - the last data word lands in slot 14 or 15 (any nbytes), or
  - it lands in slot 13 with nbytes==4.
  The second block is zeros plus any pending 0x80 and the length.
- Reset mid-operation: returns to the reset state immediately. A partial block and its length are discarded and block_valid drops.
- block_ready while block_valid=0 is ignored. din_valid outside FILL is ignored; no word is consumed.

Test Plan:
- "abc" (din=0x61626300, nbytes=3, last at s=0) -> one block: slot0=0x61626380, slots1..14=0, slot15=0x00000018, block_last=1, block_valid 16 cycles after accept.
- Empty message (din_last=1, nbytes=0) -> slot0=0x80000000, all other slots 0, block_last=1.
- 55 bytes (13 full words, last word at s=13 with nbytes=3) -> single block: slot13 byte3=0x80, slot14=0, slot15=0x000001B8, block_last=1.
- 56 bytes (last word at s=13, nbytes=4) -> block1: slot14=0x80000000, slot15=0, last=0. Block2: slots0..14=0, slot15=0x000001C0, last=1.
- 64 bytes (16 words, last at s=15, nbytes=4) -> block1 = data, last=0. Block2: slot0=0x80000000, slot15=0x00000200, last=1.
- Backpressure plus reset: hold block_ready=0 for 5 cycles -> block/block_last stable, din_ready=0. Then assert rst_n=0 during PAD of a second message -> block_valid=0 at once. A fresh "abc" then yields the exact block above with len=0x18.
